// File: rtl/fu_pkg.sv
// Shared definitions for the operand-join functional-unit front end:
// config bit positions and the constant log2 helper used for pointer/count widths.
package fu_pkg;

  // Bit positions inside config_sig
  localparam int FU_USE_IN0 = 0;
  localparam int FU_USE_IN1 = 1;

  // Ceiling log2; returns 0 for n <= 1. Used in constant contexts only.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fu_fifo.sv
// Per-operand token FIFO: DEPTH entries, wrapping read/write pointers and an
// occupancy count one bit wider than the pointers. No push/pop bypass: a push
// is refused whenever the FIFO is full at the start of the cycle, even if a pop
// happens in the same cycle.
module fu_fifo
  import fu_pkg::*;
#(
  parameter int size  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [size-1:0] data_i,
  output logic [size-1:0] head_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [size-1:0] mem_q [DEPTH];
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and count next-state; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Control state; reset empties the FIFO and drops any buffered tokens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fu_oprnd_join_2_1.sv
// Operand-join stage in front of a two-input ALU cell. Two independent
// valid/ready operand channels are buffered in per-operand FIFOs, paired in
// arrival order and presented as a registered (out0, out1) pair. Only the
// operands enabled in config_sig must be present before a pair issues.
// Optional feature macro: FU_OPRND_CONST_EN -- adds a writable constant
// register that replaces out1 when operand 1 is unused.
module fu_oprnd_join_2_1
  import fu_pkg::*;
#(
  parameter int size  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      config_sig,
  input  logic [size-1:0] in0,
  input  logic            in0_valid,
  output logic            in0_ready,
  input  logic [size-1:0] in1,
  input  logic            in1_valid,
  output logic            in1_ready,
`ifdef FU_OPRND_CONST_EN
  input  logic            const_we,
  input  logic [size-1:0] const_data,
`endif
  output logic [size-1:0] out0,
  output logic [size-1:0] out1,
  output logic            out_valid,
  input  logic            out_ready
);

  logic            use0, use1;
  logic            full0, full1, empty0, empty1;
  logic [size-1:0] head0, head1;
  logic            push0, push1, pop0, pop1;
  logic            have_ops, issue;
  logic [size-1:0] fill1;

  logic            out_valid_q, out_valid_d;
  logic [size-1:0] out0_q, out0_d;
  logic [size-1:0] out1_q, out1_d;

  assign use0 = config_sig[FU_USE_IN0];
  assign use1 = config_sig[FU_USE_IN1];

  // Ready is forced low during reset so no token is taken while state is cleared
  assign in0_ready = rst_n && use0 && !full0;
  assign in1_ready = rst_n && use1 && !full1;

  assign push0 = in0_valid && in0_ready;
  assign push1 = in1_valid && in1_ready;

  // A pair issues once every enabled operand has a token and the output slot is free or draining
  assign have_ops = (config_sig != 2'b00) && (!use0 || !empty0) && (!use1 || !empty1);
  assign issue    = have_ops && (!out_valid_q || out_ready);
  assign pop0     = issue && use0;
  assign pop1     = issue && use1;

`ifdef FU_OPRND_CONST_EN
  logic [size-1:0] const_q;

  // Constant register; an issue in the same cycle as a write still sees the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) const_q <= '0;
    else if (const_we) const_q <= const_data;
  end

  assign fill1 = const_q;
`else
  assign fill1 = '0;
`endif

  fu_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push0),
    .pop_i   (pop0),
    .data_i  (in0),
    .head_o  (head0),
    .full_o  (full0),
    .empty_o (empty0)
  );

  fu_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push1),
    .pop_i   (pop1),
    .data_i  (in1),
    .head_o  (head1),
    .full_o  (full1),
    .empty_o (empty1)
  );

  // Output pair next-state: load on issue, otherwise drop valid once consumed; data holds
  always_comb begin
    out_valid_d = out_valid_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    if (issue) begin
      out_valid_d = 1'b1;
      out0_d      = use0 ? head0 : '0;
      out1_d      = use1 ? head1 : fill1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output pair register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out0      = out0_q;
  assign out1      = out1_q;

endmodule

// File: doc/fu_oprnd_join_2_1.md
# fu_oprnd_join_2_1

Operand-join stage placed directly upstream of a two-input ALU functional cell in the CGRA fabric. Buffers operand tokens arriving independently from the routing network on two valid/ready channels, pairs them in arrival order and presents a registered operand pair (out0, out1) with a valid/ready handshake. Only the operands selected by the configuration must be present before a pair issues. The ALU therefore sees aligned operands regardless of skew between routing paths.

## Interface
- size, 32, data width of every operand
- DEPTH, 2, per-operand FIFO depth; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- config_sig  in  2  bit0 = in0 used, bit1 = in1 used; static while FIFOs are non-empty
- in0 / in1  in  size  operand data
- in0_valid / in1_valid  in  1  operand present
- in0_ready / in1_ready  out  1  operand accepted when valid && ready
- out0 / out1  out  size  registered operand pair to the ALU
- out_valid  out  1  pair present on out0/out1
- out_ready  in  1  downstream accepts the pair

## Operation
- Per operand a DEPTH-entry FIFO: write pointer, read pointer, count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- inX_ready = config_sig[X] && (countX != DEPTH). An unused operand port has ready held at 0.
- A pop never frees a slot for a push in the same cycle (no bypass). A push and a pop on a non-full FIFO in the same cycle leave the count unchanged.
- Issue condition: config_sig != 0, every used FIFO is non-empty, and (!out_valid || out_ready).
- On issue:
  - Pop each used FIFO.
  - Load out0/out1 from the FIFO heads; an unused operand loads 0, or the constant under the macro.
  - Set out_valid.
- If out_valid && out_ready and there is no issue, clear out_valid. out0/out1 hold their last values.
- config_sig = 00: nothing issues, all readys are 0, and an existing out_valid still drains normally.
- Changing config_sig with data buffered is illegal. Entries in a now-unused FIFO are retained, not discarded.
- Reset, including mid-operation: all counts and pointers go to 0, out_valid = 0, out0 = out1 = 0, and in-flight tokens are lost. Output while rst_n is low: in0_ready = in1_ready = 0.

## Timing
- Latency: operand accepted at edge k, pair valid after edge k+1 (one cycle), provided out_valid was clear or out_ready was high at k+1.
- Throughput: one pair per cycle while both used FIFOs are fed and out_ready stays high.
- Back-to-back issue: when out_valid && out_ready and the issue condition holds in the same cycle, the new pair replaces the old one and out_valid stays 1.
- Operands skewed by N cycles: the pair issues one edge after the later operand is accepted.
- Full FIFO: ready is low for exactly the cycles where count == DEPTH, and rises the cycle after a pop.

## Configuration
- FU_OPRND_CONST_EN defined:
  - Adds ports const_we (in, 1) and const_data (in, size).
  - A size-wide constant register is written on clk when const_we = 1; its reset value is 0.
  - When config_sig[1] = 0, out1 loads the constant instead of 0.
  - A write coinciding with an issue does not take effect for that issue; the pair uses the old constant.
- Undefined: no constant register or ports, and an unused operand is always 0.

## Structure
- Shared package fu_pkg:
  - config bit positions FU_USE_IN0 = 0 and FU_USE_IN1 = 1,
  - the count-width function clog2.
- One sub-module, fu_fifo (size, DEPTH): push/pop/full/empty/head. It is instantiated twice. All issue and output-register logic stays in the top.

## Test plan
- Config 11, in0 = 5 at cycle 0 and in1 = 7 at cycle 3, out_ready = 1 -> out_valid rises after edge 4 with out0 = 5, out1 = 7, and exactly one pair is produced.
- Config 11, stream in0 = 1,2,3 and in1 = 10,20,30 each cycle, out_ready = 1 -> pairs (1,10), (2,20), (3,30) on consecutive cycles.
- Config 11, out_ready = 0, push 3 tokens on in0 -> in0_ready drops after 2 accepts (DEPTH = 2). Raising out_ready and feeding in1 drains every token in order.
- Config 01, in0 = 9, in1_valid = 1 -> in1_ready = 0, pair issues as (9, 0).
- Reset asserted with 1 entry buffered and out_valid = 1 -> out_valid = 0 and all readys = 0 immediately. After release, a fresh pair issues with no stale data.
- FU_OPRND_CONST_EN: write const 0x2A, config 01, in0 = 3 -> pair (3, 0x2A).
